reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  Parametrised register file for the pipelined datapath: one write port, two registered read ports.
//  Adds write-to-read bypass, per-register busy bits (scoreboard) and a read-hazard flag.
//  Sits between decode (reads, reservations) and write-back (writes); hazard feeds the stall logic.
// PARAMETERS
//  WORD_LENGTH  8  data width of every register, in bits
//  ADDR_WIDTH   3  register address width; depth = 2**ADDR_WIDTH
// PORTS
//  clk           in   1            rising-edge clock
//  reset         in   1            synchronous, active-high reset
//  write_en      in   1            write register write_addr this edge
//  write_addr    in   ADDR_WIDTH   write target
//  write_data    in   WORD_LENGTH  write value
//  rd_en         in   1            read request (both ports)
//  rd_addr_1     in   ADDR_WIDTH   read port 1 address
//  rd_addr_2     in   ADDR_WIDTH   read port 2 address
//  rd_data_1     out  WORD_LENGTH  registered read data, port 1
//  rd_data_2     out  WORD_LENGTH  registered read data, port 2
//  rd_valid      out  1            rd_data_1/2 updated this cycle
//  reserve_en    in   1            mark reserve_addr busy (pending write)
//  reserve_addr  in   ADDR_WIDTH   register being reserved
//  busy_1        out  1            rd_addr_1 has a pending write (comb.)
//  busy_2        out  1            rd_addr_2 has a pending write (comb.)
//  hazard        out  1            rd_en & (busy_1 | busy_2) (comb.)
// BEHAVIOUR
//  - Single clock clk; reset is synchronous and active-high. On reset: all registers, busy bits,
//    rd_data_1/2 and rd_valid = 0. Reset wins over every concurrent write/reserve/read.
//  - Write: at edge with write_en, reg[write_addr] <= write_data, busy[write_addr] <= 0.
//  - Reserve: at edge with reserve_en, busy[reserve_addr] <= 1. Reserve and write to the same
//    address in one cycle: data written AND busy stays 1 (new producer wins).
//  - busy_x = busy[rd_addr_x], except 0 when write_en & write_addr==rd_addr_x and no same-cycle
//    reserve to that address (bypass clears hazard in the completing cycle).
//  - Read: latency 1. At edge with rd_en & !hazard: rd_data_x <= bypassed value
//    (write_data if write_en & write_addr==rd_addr_x, else reg[rd_addr_x]); rd_valid <= 1.
//  - If rd_en & hazard: rd_data_1/2 hold, rd_valid <= 0; requester must hold rd_en/addresses.
//  - rd_en low: rd_data hold, rd_valid <= 0. Same address on both ports is legal.
//  - Addresses are full-range; no out-of-range case. Reservation of an already-busy reg: stays 1.
// CONFIGURATION
//  ZERO_REG_EN defined: register 0 is hardwired zero — writes and reserves to address 0 ignored,
//    busy[0] always 0, reads of address 0 (incl. bypass) return 0.
//  ZERO_REG_EN undefined: register 0 is an ordinary register.
// STRUCTURE
//  Package reg_file_pkg: default WORD_LENGTH/ADDR_WIDTH constants, REG_ZERO address constant.
//  Sub-module reg_scoreboard: busy-bit vector with set (reserve), clear (write), reset, and
//    two combinational lookups with bypass; top holds storage array, read muxes, output regs.
// TESTING (WORD_LENGTH=8, ADDR_WIDTH=3)
//  1. reset=1 for 1 cycle then rd_en, addr 5/6 -> next cycle rd_data 0x00/0x00, rd_valid=1.
//  2. write 0xA5 to r3; next cycle read r3 on both ports -> rd_data_1=rd_data_2=0xA5.
//  3. write 0x3C to r2 and rd_en addr_1=2 same cycle -> next cycle rd_data_1=0x3C (bypass).
//  4. reserve r4; rd_en addr_2=4 -> busy_2=1, hazard=1, rd_valid=0; write 0x77 to r4 with rd_en held
//     -> hazard=0 that cycle, next cycle rd_data_2=0x77, rd_valid=1.
//  5. reserve r1 and write 0x11 to r1 same cycle -> busy[1] stays 1; r1 reads 0x11 once cleared.
//  6. ZERO_REG_EN: write 0xFF and reserve r0, read r0 -> rd_data 0x00, busy 0; without macro -> 0xFF.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file with scoreboard.
package reg_file_pkg;

  localparam int unsigned DEFAULT_WORD_LENGTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH  = 3;
  localparam int unsigned REG_ZERO            = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back side bus of the register file: write, read, reserve and hazard signals.
interface reg_file_scoreboard_if
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
);

  logic                   write_en;
  logic [ADDR_WIDTH-1:0]  write_addr;
  logic [WORD_LENGTH-1:0] write_data;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr_1;
  logic [ADDR_WIDTH-1:0]  rd_addr_2;
  logic [WORD_LENGTH-1:0] rd_data_1;
  logic [WORD_LENGTH-1:0] rd_data_2;
  logic                   rd_valid;
  logic                   reserve_en;
  logic [ADDR_WIDTH-1:0]  reserve_addr;
  logic                   busy_1;
  logic                   busy_2;
  logic                   hazard;

  modport master (
    output write_en, write_addr, write_data, rd_en, rd_addr_1, rd_addr_2,
           reserve_en, reserve_addr,
    input  rd_data_1, rd_data_2, rd_valid, busy_1, busy_2, hazard
  );

  modport slave (
    input  write_en, write_addr, write_data, rd_en, rd_addr_1, rd_addr_2,
           reserve_en, reserve_addr,
    output rd_data_1, rd_data_2, rd_valid, busy_1, busy_2, hazard
  );

endinterface : reg_file_scoreboard_if

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by reserve, cleared by write, with same-cycle write bypass on lookup.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic                  busy_1,
  output logic                  busy_2
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             clr_1;
  logic             clr_2;

  // Reserve is applied after the write clear so a new producer keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (write_en)   busy_next[write_addr]   = 1'b0;
    if (reserve_en) busy_next[reserve_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // A completing write hides the busy bit unless it is re-reserved in the same cycle.
  always_comb begin
    clr_1  = write_en && (write_addr == rd_addr_1)
             && !(reserve_en && (reserve_addr == rd_addr_1));
    clr_2  = write_en && (write_addr == rd_addr_2)
             && !(reserve_en && (reserve_addr == rd_addr_2));
    busy_1 = busy[rd_addr_1] && !clr_1;
    busy_2 = busy[rd_addr_2] && !clr_2;
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_scoreboard.sv
// Register file, one write / two registered read ports, with bypass, scoreboard and hazard flag.
// Optional: define ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_scoreboard_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_LENGTH-1:0] regs [DEPTH];
  logic                   write_en_eff;
  logic                   reserve_en_eff;
  logic                   busy_1;
  logic                   busy_2;
  logic                   hazard;
  logic [WORD_LENGTH-1:0] rd_next_1;
  logic [WORD_LENGTH-1:0] rd_next_2;

`ifdef ZERO_REG_EN
  // Register 0 never accepts writes or reservations, so it stays at its reset value of zero.
  assign write_en_eff   = bus.write_en   && (bus.write_addr   != ADDR_WIDTH'(REG_ZERO));
  assign reserve_en_eff = bus.reserve_en && (bus.reserve_addr != ADDR_WIDTH'(REG_ZERO));
`else
  assign write_en_eff   = bus.write_en;
  assign reserve_en_eff = bus.reserve_en;
`endif

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en_eff),
    .write_addr   (bus.write_addr),
    .reserve_en   (reserve_en_eff),
    .reserve_addr (bus.reserve_addr),
    .rd_addr_1    (bus.rd_addr_1),
    .rd_addr_2    (bus.rd_addr_2),
    .busy_1       (busy_1),
    .busy_2       (busy_2)
  );

  assign hazard     = bus.rd_en && (busy_1 || busy_2);
  assign bus.busy_1 = busy_1;
  assign bus.busy_2 = busy_2;
  assign bus.hazard = hazard;

  // Read muxes with write-to-read bypass.
  always_comb begin
    rd_next_1 = regs[bus.rd_addr_1];
    rd_next_2 = regs[bus.rd_addr_2];
    if (write_en_eff && (bus.write_addr == bus.rd_addr_1)) rd_next_1 = bus.write_data;
    if (write_en_eff && (bus.write_addr == bus.rd_addr_2)) rd_next_2 = bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (write_en_eff) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // Read data only advances on a hazard-free request; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data_1 <= '0;
      bus.rd_data_2 <= '0;
      bus.rd_valid  <= 1'b0;
    end else if (bus.rd_en && !hazard) begin
      bus.rd_data_1 <= rd_next_1;
      bus.rd_data_2 <= rd_next_2;
      bus.rd_valid  <= 1'b1;
    end else begin
      bus.rd_valid  <= 1'b0;
    end
  end

endmodule : reg_file_scoreboard

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard (WORD_LENGTH=8, ADDR_WIDTH=3).
module tb_reg_file_scoreboard;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reg_file_scoreboard_if #(.WORD_LENGTH(8), .ADDR_WIDTH(3)) bus ();

  reg_file_scoreboard #(.WORD_LENGTH(8), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write_en     = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.rd_en        = 1'b0;
    bus.rd_addr_1    = '0;
    bus.rd_addr_2    = '0;
    bus.reserve_en   = 1'b0;
    bus.reserve_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.write_en = 1'b1; bus.write_addr = 3'd5; bus.write_data = 8'h55;
    bus.reserve_en = 1'b1; bus.reserve_addr = 3'd6;
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd5; bus.rd_addr_2 = 3'd6;
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data_1 !== 8'h00 || bus.rd_data_2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b d1=%h d2=%h, required 0/00/00",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd5; bus.rd_addr_2 = 3'd6;
    #1;
    checks++;
    if (bus.busy_2 !== 1'b0 || bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy_2=%b hazard=%b, required 0/0", bus.busy_2, bus.hazard);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'h00 || bus.rd_data_2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_read: valid=%b d1=%h d2=%h, required 1/00/00",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.write_en = 1'b1; bus.write_addr = 3'd3; bus.write_data = 8'hA5;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: valid=%b, required 0", bus.rd_valid);
    end
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd3; bus.rd_addr_2 = 3'd3;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'hA5 || bus.rd_data_2 !== 8'hA5) begin
      errors++;
      $display("FAIL write_read: valid=%b d1=%h d2=%h, required 1/a5/a5",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
    idle();
    bus.rd_addr_1 = 3'd0; bus.rd_addr_2 = 3'd1;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data_1 !== 8'hA5 || bus.rd_data_2 !== 8'hA5) begin
      errors++;
      $display("FAIL hold_no_rd: valid=%b d1=%h d2=%h, required 0/a5/a5",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.write_en = 1'b1; bus.write_addr = 3'd2; bus.write_data = 8'h3C;
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd2; bus.rd_addr_2 = 3'd3;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'h3C || bus.rd_data_2 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass: valid=%b d1=%h d2=%h, required 1/3c/a5",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
  endtask

  task automatic test_hazard();
    idle();
    bus.reserve_en = 1'b1; bus.reserve_addr = 3'd4;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd3; bus.rd_addr_2 = 3'd4;
    #1;
    checks++;
    if (bus.busy_1 !== 1'b0 || bus.busy_2 !== 1'b1 || bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_set: busy_1=%b busy_2=%b hazard=%b, required 0/1/1",
               bus.busy_1, bus.busy_2, bus.hazard);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data_1 !== 8'h3C || bus.rd_data_2 !== 8'hA5) begin
      errors++;
      $display("FAIL hazard_stall: valid=%b d1=%h d2=%h, required 0/3c/a5",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
    bus.write_en = 1'b1; bus.write_addr = 3'd4; bus.write_data = 8'h77;
    #1;
    checks++;
    if (bus.busy_2 !== 1'b0 || bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_bypass: busy_2=%b hazard=%b, required 0/0", bus.busy_2, bus.hazard);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'hA5 || bus.rd_data_2 !== 8'h77) begin
      errors++;
      $display("FAIL hazard_release: valid=%b d1=%h d2=%h, required 1/a5/77",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
    bus.write_en = 1'b0;
    #1;
    checks++;
    if (bus.busy_2 !== 1'b0) begin
      errors++;
      $display("FAIL busy_cleared: busy_2=%b, required 0", bus.busy_2);
    end
  endtask

  task automatic test_reserve_write_same();
    idle();
    bus.reserve_en = 1'b1; bus.reserve_addr = 3'd1;
    bus.write_en = 1'b1; bus.write_addr = 3'd1; bus.write_data = 8'h11;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd1; bus.rd_addr_2 = 3'd2;
    #1;
    checks++;
    if (bus.busy_1 !== 1'b1 || bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL reserve_write_busy: busy_1=%b hazard=%b, required 1/1", bus.busy_1, bus.hazard);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reserve_write_stall: valid=%b, required 0", bus.rd_valid);
    end
    bus.write_en = 1'b1; bus.write_addr = 3'd1; bus.write_data = 8'h11;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'h11 || bus.rd_data_2 !== 8'h3C) begin
      errors++;
      $display("FAIL reserve_write_read: valid=%b d1=%h d2=%h, required 1/11/3c",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
    // Re-reserving an already busy register keeps it busy.
    idle();
    bus.reserve_en = 1'b1; bus.reserve_addr = 3'd6;
    tick();
    tick();
    bus.reserve_en = 1'b0;
    bus.rd_addr_1 = 3'd6;
    #1;
    checks++;
    if (bus.busy_1 !== 1'b1) begin
      errors++;
      $display("FAIL double_reserve: busy_1=%b, required 1", bus.busy_1);
    end
    bus.write_en = 1'b1; bus.write_addr = 3'd6; bus.write_data = 8'h66;
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.write_en = 1'b1; bus.write_addr = 3'd0; bus.write_data = 8'hFF;
    bus.reserve_en = 1'b1; bus.reserve_addr = 3'd0;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_1 = 3'd0; bus.rd_addr_2 = 3'd0;
    #1;
`ifdef ZERO_REG_EN
    checks++;
    if (bus.busy_1 !== 1'b0 || bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: busy_1=%b hazard=%b, required 0/0", bus.busy_1, bus.hazard);
    end
    bus.write_en = 1'b1; bus.write_addr = 3'd0; bus.write_data = 8'hFF;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'h00 || bus.rd_data_2 !== 8'h00) begin
      errors++;
      $display("FAIL zero_read: valid=%b d1=%h d2=%h, required 1/00/00",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
`else
    checks++;
    if (bus.busy_1 !== 1'b1 || bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy: busy_1=%b hazard=%b, required 1/1", bus.busy_1, bus.hazard);
    end
    tick();
    bus.write_en = 1'b1; bus.write_addr = 3'd0; bus.write_data = 8'hFF;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data_1 !== 8'hFF || bus.rd_data_2 !== 8'hFF) begin
      errors++;
      $display("FAIL zero_read: valid=%b d1=%h d2=%h, required 1/ff/ff",
               bus.rd_valid, bus.rd_data_1, bus.rd_data_2);
    end
`endif
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_reserve_write_same();
    test_zero_reg();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_scoreboard
